// File: rtl/btn_debouncer_bank.sv
// btn_debouncer_bank
//   A bank of independent push-button conditioners. Each channel has a
//   two-stage synchroniser, a symmetric debounce counter, click/release edge
//   pulses, a saturating long-press detector and (optionally) auto-repeat.
//   All counters and synchronisers advance only on ce ticks; one-cycle pulses
//   are re-evaluated every clk, so they always clear after one cycle.
//
// Optional feature macro: BTN_DEBOUNCER_AUTOREPEAT_EN
//   defined   -> auto-repeat counter and btn_repeat pulses are built
//   undefined -> btn_repeat is tied to 0 and no repeat counter exists
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   ce             in   sample tick / clock enable
//   btn            in   raw button levels, 1 = pressed
//   btn_debounced  out  debounced level per channel
//   btn_click      out  one-clk pulse on debounced 0->1
//   btn_release    out  one-clk pulse on debounced 1->0
//   btn_long       out  one-clk pulse when a press reaches 2^LONG_WIDTH-1 ticks
//   btn_repeat     out  one-clk auto-repeat pulses (feature macro)
//   any_pressed    out  registered OR of btn_debounced
module btn_debouncer_bank #(
  parameter int CHANNELS      = 4,
  parameter int COUNTER_WIDTH = 2,
  parameter int LONG_WIDTH    = 8,
  parameter int REPEAT_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] btn_debounced,
  output logic [CHANNELS-1:0] btn_click,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long,
  output logic [CHANNELS-1:0] btn_repeat,
  output logic                any_pressed
);

  logic [CHANNELS-1:0]      sync0_q, sync0_d;
  logic [CHANNELS-1:0]      sync1_q, sync1_d;
  logic [CHANNELS-1:0]      state_q, state_d;
  logic [CHANNELS-1:0]      click_q, click_d;
  logic [CHANNELS-1:0]      release_q, release_d;
  logic [CHANNELS-1:0]      long_q, long_d;
  logic                     any_q, any_d;
  logic [COUNTER_WIDTH-1:0] cnt_q [CHANNELS];
  logic [COUNTER_WIDTH-1:0] cnt_d [CHANNELS];
  logic [LONG_WIDTH-1:0]    lcnt_q [CHANNELS];
  logic [LONG_WIDTH-1:0]    lcnt_d [CHANNELS];
`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
  logic [CHANNELS-1:0]      repeat_q, repeat_d;
  logic [REPEAT_WIDTH-1:0]  rcnt_q [CHANNELS];
  logic [REPEAT_WIDTH-1:0]  rcnt_d [CHANNELS];
`endif

  always_comb begin
    sync0_d   = sync0_q;
    sync1_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    lcnt_d    = lcnt_q;
    click_d   = '0;
    release_d = '0;
    long_d    = '0;
    // Registered from the current state, so it trails btn_debounced by one clk.
    any_d     = |state_q;
`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
    rcnt_d    = rcnt_q;
    repeat_d  = '0;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      if (ce) begin
        sync0_d[c] = btn[c];
        sync1_d[c] = sync0_q[c];

        // Symmetric debounce: count disagreeing ticks, toggle on the tick
        // after the counter is already all-ones (so the counter never wraps).
        if (sync1_q[c] != state_q[c]) begin
          if (&cnt_q[c]) begin
            state_d[c]   = ~state_q[c];
            cnt_d[c]     = '0;
            click_d[c]   = ~state_q[c];
            release_d[c] = state_q[c];
          end else begin
            cnt_d[c] = cnt_q[c] + COUNTER_WIDTH'(1);
          end
        end else begin
          cnt_d[c] = '0;
        end

        // Long-press: saturating, so the pulse fires only once per press.
        if (!state_q[c] || release_d[c]) begin
          lcnt_d[c] = '0;
        end else if (!(&lcnt_q[c])) begin
          lcnt_d[c] = lcnt_q[c] + LONG_WIDTH'(1);
          long_d[c] = &lcnt_d[c];
        end

`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
        // Repeat counter only runs once the long-press counter has saturated;
        // it wraps freely, pulsing each time it passes all-ones.
        if (!state_q[c] || release_d[c] || !(&lcnt_q[c])) begin
          rcnt_d[c] = '0;
        end else begin
          rcnt_d[c]   = rcnt_q[c] + REPEAT_WIDTH'(1);
          repeat_d[c] = &rcnt_q[c];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q   <= '0;
      sync1_q   <= '0;
      state_q   <= '0;
      click_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      any_q     <= 1'b0;
      cnt_q     <= '{default: '0};
      lcnt_q    <= '{default: '0};
`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
      repeat_q  <= '0;
      rcnt_q    <= '{default: '0};
`endif
    end else begin
      sync0_q   <= sync0_d;
      sync1_q   <= sync1_d;
      state_q   <= state_d;
      click_q   <= click_d;
      release_q <= release_d;
      long_q    <= long_d;
      any_q     <= any_d;
      cnt_q     <= cnt_d;
      lcnt_q    <= lcnt_d;
`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
      repeat_q  <= repeat_d;
      rcnt_q    <= rcnt_d;
`endif
    end
  end

  assign btn_debounced = state_q;
  assign btn_click     = click_q;
  assign btn_release   = release_q;
  assign btn_long      = long_q;
  assign any_pressed   = any_q;
`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
  assign btn_repeat    = repeat_q;
`else
  assign btn_repeat    = '0;
`endif

endmodule

// File: tb/tb_btn_debouncer_bank.sv
module tb_btn_debouncer_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [3:0] btn;
  logic [3:0] db, click, rel, lng, rep;
  logic       any;

  int n_checks = 0;
  int n_fail   = 0;

  btn_debouncer_bank #(
    .CHANNELS(4), .COUNTER_WIDTH(2), .LONG_WIDTH(4), .REPEAT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .btn(btn),
    .btn_debounced(db), .btn_click(click), .btn_release(rel),
    .btn_long(lng), .btn_repeat(rep), .any_pressed(any)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_db"}, {28'd0, db}, 0);
    check({tag, "_click"}, {28'd0, click}, 0);
    check({tag, "_rel"}, {28'd0, rel}, 0);
    check({tag, "_long"}, {28'd0, lng}, 0);
    check({tag, "_rep"}, {28'd0, rep}, 0);
    check({tag, "_any"}, {31'd0, any}, 0);
  endtask

  // Press on channel 3 with ce every 4th clk: ticks on clks 4,8,..., so the
  // six ticks needed land the rise on clk 24 (rise_at > n means no rise).
  task automatic run_div4(input int n, input int rise_at);
    for (int i = 1; i <= n; i++) begin
      ce = ((i % 4) == 0);
      step(1);
      check("d_db", {28'd0, db}, (i >= rise_at) ? 32'h8 : 32'h0);
      check("d_click", {28'd0, click}, (i == rise_at) ? 32'h8 : 32'h0);
      check("d_rel", {28'd0, rel}, 0);
      check("d_long", {28'd0, lng}, 0);
      check("d_any", {31'd0, any}, (i >= rise_at + 1) ? 32'h1 : 32'h0);
    end
    ce = 1'b1;
  endtask

  function automatic logic [31:0] rep_exp(input int abs_i);
`ifdef BTN_DEBOUNCER_AUTOREPEAT_EN
    // long at press clk 21, repeats every 4 ticks from clk 25 while debounced high
    return (abs_i >= 25 && ((abs_i - 25) % 4) == 0) ? 32'h4 : 32'h0;
`else
    return (abs_i < 0) ? 32'h4 : 32'h0;
`endif
  endfunction

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    btn = 4'b0000;
    step(2);
    check_all_zero("reset");
    rst = 1'b0;

    // A: single press on channel 0, rise after 6 clks, short hold then release
    btn = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("a_db", {28'd0, db}, (i >= 6) ? 32'h1 : 32'h0);
      check("a_click", {28'd0, click}, (i == 6) ? 32'h1 : 32'h0);
      check("a_rel", {28'd0, rel}, 0);
      check("a_long", {28'd0, lng}, 0);
      check("a_any", {31'd0, any}, (i >= 7) ? 32'h1 : 32'h0);
    end
    btn = 4'b0000;
    for (int j = 1; j <= 8; j++) begin
      step(1);
      check("a_rel_db", {28'd0, db}, (j < 6) ? 32'h1 : 32'h0);
      check("a_rel_pulse", {28'd0, rel}, (j == 6) ? 32'h1 : 32'h0);
      check("a_rel_click", {28'd0, click}, 0);
      check("a_rel_long", {28'd0, lng}, 0);
      check("a_rel_any", {31'd0, any}, (j < 7) ? 32'h1 : 32'h0);
    end

    // B: 3-clk glitch on channel 1 is filtered
    btn = 4'b0010;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) btn = 4'b0000;
      step(1);
      check("b_db", {28'd0, db}, 0);
      check("b_click", {28'd0, click}, 0);
      check("b_rel", {28'd0, rel}, 0);
    end

    // C: long hold on channel 2, long-press and repeats
    btn = 4'b0100;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      check("c_db", {28'd0, db}, (i >= 6) ? 32'h4 : 32'h0);
      check("c_click", {28'd0, click}, (i == 6) ? 32'h4 : 32'h0);
      check("c_long", {28'd0, lng}, (i == 21) ? 32'h4 : 32'h0);
      check("c_rep", {28'd0, rep}, rep_exp(i));
    end
    btn = 4'b0000;
    for (int j = 1; j <= 8; j++) begin
      step(1);
      check("c_rel_db", {28'd0, db}, (j < 6) ? 32'h4 : 32'h0);
      check("c_rel_pulse", {28'd0, rel}, (j == 6) ? 32'h4 : 32'h0);
      check("c_rel_long", {28'd0, lng}, 0);
      check("c_rel_rep", {28'd0, rep}, (j <= 5) ? rep_exp(40 + j) : 32'h0);
    end

    // S: simultaneous press and release on three channels
    btn = 4'b1011;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check("s_db", {28'd0, db}, (i >= 6) ? 32'hb : 32'h0);
      check("s_click", {28'd0, click}, (i == 6) ? 32'hb : 32'h0);
    end
    btn = 4'b0000;
    for (int j = 1; j <= 8; j++) begin
      step(1);
      check("s_rel", {28'd0, rel}, (j == 6) ? 32'hb : 32'h0);
      check("s_rel_db", {28'd0, db}, (j < 6) ? 32'hb : 32'h0);
    end

    // D: divided ce, then reset while held, then reset mid-debounce
    btn = 4'b1000;
    run_div4(26, 24);
    rst = 1'b1;
    step(1);
    check_all_zero("d_rst_held");
    rst = 1'b0;
    run_div4(26, 24);

    btn = 4'b0000;
    step(8);
    check("d_idle_db", {28'd0, db}, 0);
    btn = 4'b1000;
    run_div4(12, 1000);
    rst = 1'b1;
    step(1);
    check_all_zero("d_rst_mid");
    rst = 1'b0;
    run_div4(26, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
